// File: rtl/grid_vga_renderer.sv
// grid_vga_renderer: VGA timing plus cell-grid raster with palette and cursor.
// Pipeline: S0 counters, S1 class/address, S2 RAM data, S3 output register.
module grid_vga_renderer #(
  parameter int COLS      = 40,
  parameter int ROWS      = 25,
  parameter int CELL_W    = 16,
  parameter int CELL_H    = 16,
  parameter int CELL_BITS = 1,
  parameter int ADDR_W    = (COLS * ROWS > 1) ? $clog2(COLS * ROWS) : 1
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [11:0]                     h_total,
  input  logic [11:0]                     h_sync,
  input  logic [11:0]                     h_start,
  input  logic [11:0]                     h_end,
  input  logic [11:0]                     v_total,
  input  logic [11:0]                     v_sync,
  input  logic [11:0]                     v_start,
  input  logic [11:0]                     v_end,
  input  logic [24*(2**CELL_BITS)-1:0]    palette,
  input  logic [15:0]                     cursor_x,
  input  logic [15:0]                     cursor_y,
  output logic [ADDR_W-1:0]               map_addr,
  input  logic [CELL_BITS-1:0]            map_data,
  output logic                            frame_start,
  output logic                            vga_hs,
  output logic                            vga_vs,
  output logic                            vga_de,
  output logic [7:0]                      vga_r,
  output logic [7:0]                      vga_g,
  output logic [7:0]                      vga_b
);

  localparam int CXW = $clog2(COLS + 1);
  localparam int CYW = $clog2(ROWS + 1);
  localparam int PXW = $clog2(CELL_W);
  localparam int PYW = $clog2(CELL_H);

  localparam logic [CXW-1:0]    COLS_C   = CXW'(COLS);
  localparam logic [CYW-1:0]    ROWS_C   = CYW'(ROWS);
  localparam logic [CYW-1:0]    ROW_LAST = CYW'(ROWS - 1);
  localparam logic [PXW-1:0]    PX_MAX   = PXW'(CELL_W - 1);
  localparam logic [PYW-1:0]    PY_MAX   = PYW'(CELL_H - 1);
  localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);

  typedef enum logic [2:0] {
    K_BLANK, K_EDGE, K_WHITE, K_CURSOR, K_CELL
  } kind_t;

  logic [11:0]       h_count, v_count, h_next, v_next;
  logic              h_wrap, v_wrap;
  logic [PXW-1:0]    px;
  logic [PYW-1:0]    py;
  logic [CXW-1:0]    cx;
  logic [CYW-1:0]    cy;
  logic [ADDR_W-1:0] row_base;

  logic  active, on_edge, in_grid, gline, cur_hit;
  kind_t kind;

  kind_t s1_kind, s2_kind;
  logic  s1_hs, s1_vs, s1_de, s1_fs;
  logic  s2_hs, s2_vs, s2_de, s2_fs;
  logic [23:0] pal, rgb;

  // Wrap with >= so a timing change below the current count cannot stall.
  always_comb begin
    h_wrap = (h_count >= h_total);
    v_wrap = (v_count >= v_total);
    h_next = h_wrap ? 12'd0 : h_count + 12'd1;
    v_next = v_wrap ? 12'd0 : v_count + 12'd1;
  end

  // S0: raster counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_count <= '0;
      v_count <= '0;
    end else begin
      h_count <= h_next;
      if (h_wrap) v_count <= v_next;
    end
  end

  // S0: horizontal cell position, reloaded as the line reaches h_start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      px <= '0;
      cx <= '0;
    end else if (h_next == h_start) begin
      px <= '0;
      cx <= '0;
    end else if (px == PX_MAX) begin
      px <= '0;
      if (cx != COLS_C) cx <= cx + 1'b1;
    end else begin
      px <= px + 1'b1;
    end
  end

  // S0: vertical cell position and row base, stepped once per line.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      py       <= '0;
      cy       <= '0;
      row_base <= '0;
    end else if (h_wrap) begin
      if (v_next == v_start) begin
        py       <= '0;
        cy       <= '0;
        row_base <= '0;
      end else if (py == PY_MAX) begin
        py <= '0;
        if (cy != ROWS_C) begin
          cy <= cy + 1'b1;
          if (cy != ROW_LAST) row_base <= row_base + COLS_A;
        end
      end else begin
        py <= py + 1'b1;
      end
    end
  end

  // Pixel classification in priority order.
  always_comb begin
    active  = (h_count >= h_start) && (h_count < h_end) &&
              (v_count >= v_start) && (v_count < v_end);
    on_edge = (h_count == h_start) || (h_count == h_end - 12'd1) ||
              (v_count == v_start) || (v_count == v_end - 12'd1);
    in_grid = (cx < COLS_C) && (cy < ROWS_C);
    gline   = (px == '0) || (px == PX_MAX) ||
              (py == '0) || (py == PY_MAX);
    cur_hit = (16'(cx) == cursor_x) && (16'(cy) == cursor_y);
    if (!active)            kind = K_BLANK;
    else if (on_edge)       kind = K_EDGE;
    else if (!in_grid)      kind = K_WHITE;
    else if (gline && cur_hit) kind = K_CURSOR;
    else if (gline)         kind = K_EDGE;
    else                    kind = K_CELL;
  end

  // S1: register class, syncs and the map address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_kind  <= K_BLANK;
      s1_hs    <= 1'b1;
      s1_vs    <= 1'b1;
      s1_de    <= 1'b0;
      s1_fs    <= 1'b0;
      map_addr <= '0;
    end else begin
      s1_kind <= kind;
      s1_hs   <= !(h_count < h_sync);
      s1_vs   <= !(v_count < v_sync);
      s1_de   <= active;
      s1_fs   <= (h_count == 12'd0) && (v_count == 12'd0);
      if (active && in_grid) map_addr <= row_base + ADDR_W'(cx);
    end
  end

  // S2: wait one cycle for the RAM read to land.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_kind <= K_BLANK;
      s2_hs   <= 1'b1;
      s2_vs   <= 1'b1;
      s2_de   <= 1'b0;
      s2_fs   <= 1'b0;
    end else begin
      s2_kind <= s1_kind;
      s2_hs   <= s1_hs;
      s2_vs   <= s1_vs;
      s2_de   <= s1_de;
      s2_fs   <= s1_fs;
    end
  end

  assign pal = palette[24*map_data +: 24];

  // Colour decode from class and fetched cell state.
  always_comb begin
    rgb = 24'h000000;
    unique case (s2_kind)
      K_BLANK:  rgb = 24'h000000;
      K_EDGE:   rgb = 24'h32D8E0;
      K_WHITE:  rgb = 24'hFFFFFF;
      K_CURSOR: rgb = 24'hFF5C39;
      K_CELL:   rgb = pal;
      default:  rgb = 24'h000000;
    endcase
  end

  // S3: output register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vga_hs      <= 1'b1;
      vga_vs      <= 1'b1;
      vga_de      <= 1'b0;
      frame_start <= 1'b0;
      {vga_r, vga_g, vga_b} <= 24'h000000;
    end else begin
      vga_hs      <= s2_hs;
      vga_vs      <= s2_vs;
      vga_de      <= s2_de;
      frame_start <= s2_fs;
      {vga_r, vga_g, vga_b} <= rgb;
    end
  end

endmodule

// File: tb/tb_grid_vga_renderer.sv
// tb_grid_vga_renderer: directed checks of sync, addressing, colour classes,
// cursor, out-of-grid, 2-bit cells and mid-frame reset.
module tb_grid_vga_renderer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [11:0] h_total, h_sync, h_start, h_end;
  logic [11:0] v_total, v_sync, v_start, v_end;
  logic [15:0] cursor_x, cursor_y;
  logic [47:0] pal1;
  logic [95:0] pal2;

  logic [2:0]  ma1, ma2;
  logic [0:0]  md1;
  logic [1:0]  md2;
  logic        fs1, hs1, vs1, de1, fs2, hs2, vs2, de2;
  logic [7:0]  r1, g1, b1, r2, g2, b2;

  logic [0:0]  mem1 [0:7];
  logic [1:0]  mem2 [0:7];
  logic [27:0] cap [0:239];

  int edges;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  grid_vga_renderer #(
    .COLS(3), .ROWS(2), .CELL_W(4), .CELL_H(3), .CELL_BITS(1)
  ) u1 (
    .clk(clk), .reset_n(reset_n),
    .h_total(h_total), .h_sync(h_sync), .h_start(h_start), .h_end(h_end),
    .v_total(v_total), .v_sync(v_sync), .v_start(v_start), .v_end(v_end),
    .palette(pal1), .cursor_x(cursor_x), .cursor_y(cursor_y),
    .map_addr(ma1), .map_data(md1), .frame_start(fs1),
    .vga_hs(hs1), .vga_vs(vs1), .vga_de(de1),
    .vga_r(r1), .vga_g(g1), .vga_b(b1)
  );

  grid_vga_renderer #(
    .COLS(3), .ROWS(2), .CELL_W(4), .CELL_H(3), .CELL_BITS(2)
  ) u2 (
    .clk(clk), .reset_n(reset_n),
    .h_total(h_total), .h_sync(h_sync), .h_start(h_start), .h_end(h_end),
    .v_total(v_total), .v_sync(v_sync), .v_start(v_start), .v_end(v_end),
    .palette(pal2), .cursor_x(cursor_x), .cursor_y(cursor_y),
    .map_addr(ma2), .map_data(md2), .frame_start(fs2),
    .vga_hs(hs2), .vga_vs(vs2), .vga_de(de2),
    .vga_r(r2), .vga_g(g2), .vga_b(b2)
  );

  // 1-cycle synchronous-read map RAMs.
  always @(posedge clk) begin
    md1 <= mem1[ma1];
    md2 <= mem2[ma2];
  end

  // Posedges since reset release; after edge k the counters sit at pixel k.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) edges <= 0;
    else          edges <= edges + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_edge(input int target);
    int guard;
    guard = 0;
    while (edges < target && guard < 2000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    chk("sync", edges, target);
  endtask

  task automatic at_pix(input int f, input int h, input int v);
    wait_edge(f * 240 + v * 20 + h + 3);
  endtask

  task automatic at_addr(input int f, input int h, input int v);
    wait_edge(f * 240 + v * 20 + h + 1);
  endtask

  task automatic pix(input string tag, input logic [23:0] exp);
    chk(tag, {8'h00, r1, g1, b1}, {8'h00, exp});
  endtask

  task automatic scan_frame(input int f, input bit cap_en, input bit cmp_en);
    int hs_lo, vs_lo, de_hi, fs_hi, cur, diff;
    logic [27:0] w;
    hs_lo = 0; vs_lo = 0; de_hi = 0; fs_hi = 0; cur = 0; diff = 0;
    wait_edge(f * 240 + 3);
    for (int p = 0; p < 240; p++) begin
      if (p != 0) begin
        @(posedge clk);
        #1;
      end
      w = {hs1, vs1, de1, fs1, r1, g1, b1};
      if (!hs1) hs_lo++;
      if (!vs1) vs_lo++;
      if (de1)  de_hi++;
      if (fs1)  fs_hi++;
      if ({r1, g1, b1} == 24'hFF5C39) cur++;
      if (cap_en) cap[p] = w;
      if (cmp_en && cap[p] !== w) diff++;
    end
    chk("scan_hs_low", hs_lo, 24);
    chk("scan_vs_low", vs_lo, 20);
    chk("scan_de_high", de_hi, 72);
    chk("scan_fs", fs_hi, 1);
    chk("scan_no_cursor", cur, 0);
    if (cmp_en) chk("scan_match_capture", diff, 0);
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_hs"}, hs1, 1);
    chk({tag, "_vs"}, vs1, 1);
    chk({tag, "_de"}, de1, 0);
    chk({tag, "_fs"}, fs1, 0);
    chk({tag, "_addr"}, ma1, 0);
    pix({tag, "_rgb"}, 24'h000000);
  endtask

  initial begin
    h_total = 12'd19; h_sync = 12'd2; h_start = 12'd4; h_end = 12'd16;
    v_total = 12'd11; v_sync = 12'd1; v_start = 12'd2; v_end = 12'd8;
    cursor_x = 16'd7; cursor_y = 16'd7;
    pal1 = {24'hA0B0C0, 24'h102030};
    pal2 = {24'h00FF00, 24'hFF0000, 24'h12AFAF, 24'h000000};
    mem1[0] = 1; mem1[1] = 0; mem1[2] = 1; mem1[3] = 0;
    mem1[4] = 1; mem1[5] = 0; mem1[6] = 0; mem1[7] = 0;
    mem2[0] = 2; mem2[1] = 3; mem2[2] = 1; mem2[3] = 0;
    mem2[4] = 2; mem2[5] = 2; mem2[6] = 0; mem2[7] = 0;

    repeat (3) @(posedge clk);
    #1;
    reset_vals("rst0");
    @(negedge clk);
    reset_n = 1'b1;

    wait_edge(2);
    chk("fs_pre", fs1, 0);
    at_pix(0, 0, 0);
    chk("fs_first", fs1, 1);
    chk("hs_p0", hs1, 0);
    chk("vs_p0", vs1, 0);
    chk("de_p0", de1, 0);
    at_pix(0, 1, 0);
    chk("fs_p1", fs1, 0);
    chk("hs_p1", hs1, 0);
    at_pix(0, 2, 0);
    chk("hs_p2", hs1, 1);
    at_pix(0, 5, 1);
    chk("vs_l1", vs1, 1);
    chk("de_l1", de1, 0);

    at_addr(0, 4, 2);
    chk("addr_l2_c0", ma1, 0);
    at_pix(0, 4, 2);
    chk("de_4_2", de1, 1);
    pix("rgb_corner", 24'h32D8E0);
    at_addr(0, 8, 2);
    chk("addr_l2_c1", ma1, 1);
    at_addr(0, 12, 2);
    chk("addr_l2_c2", ma1, 2);
    at_addr(0, 17, 2);
    chk("addr_hold", ma1, 2);
    at_pix(0, 16, 2);
    chk("de_16_2", de1, 0);

    at_pix(0, 5, 3);
    pix("cell0_in", 24'hA0B0C0);
    chk("cb2_cell0", {r2, g2, b2}, 24'hFF0000);
    at_pix(0, 8, 3);
    pix("gline_px0", 24'h32D8E0);
    at_pix(0, 9, 3);
    pix("cell1_in", 24'h102030);
    chk("cb2_cell1", {r2, g2, b2}, 24'h00FF00);
    at_pix(0, 13, 3);
    pix("cell2_in", 24'hA0B0C0);
    chk("cb2_cell2", {r2, g2, b2}, 24'h12AFAF);
    at_pix(0, 15, 3);
    pix("frame_right", 24'h32D8E0);
    at_pix(0, 7, 4);
    pix("gline_py2", 24'h32D8E0);

    at_addr(0, 4, 5);
    chk("addr_l5_c0", ma1, 3);
    at_addr(0, 8, 5);
    chk("addr_l5_c1", ma1, 4);
    at_addr(0, 12, 5);
    chk("addr_l5_c2", ma1, 5);
    at_pix(0, 5, 6);
    pix("cell3_in", 24'h102030);
    chk("cb2_cell3", {r2, g2, b2}, 24'h000000);
    at_pix(0, 9, 6);
    pix("cell4_in", 24'hA0B0C0);
    chk("cb2_cell4", {r2, g2, b2}, 24'hFF0000);
    at_pix(0, 13, 6);
    pix("cell5_in", 24'h102030);
    at_pix(0, 5, 8);
    chk("de_l8", de1, 0);
    pix("rgb_l8", 24'h000000);

    scan_frame(1, 1'b1, 1'b0);

    cursor_x = 16'd1; cursor_y = 16'd1;
    at_pix(2, 10, 5);
    pix("cur_top", 24'hFF5C39);
    at_pix(2, 7, 6);
    pix("cur_nbr_left", 24'h32D8E0);
    at_pix(2, 8, 6);
    pix("cur_left", 24'hFF5C39);
    at_pix(2, 9, 6);
    pix("cur_interior", 24'hA0B0C0);
    at_pix(2, 11, 6);
    pix("cur_right", 24'hFF5C39);
    at_pix(2, 12, 6);
    pix("cur_nbr_right", 24'h32D8E0);
    at_pix(2, 9, 7);
    pix("cur_frame", 24'h32D8E0);

    cursor_x = 16'd3; cursor_y = 16'd0;
    scan_frame(3, 1'b0, 1'b0);

    at_pix(4, 9 - 3, 4);
    wait_edge(4 * 240 + 4 * 20 + 9);
    chk("pre_rst_addr", ma1, 1);
    reset_n = 1'b0;
    #1;
    reset_vals("rst_mid");
    repeat (2) @(posedge clk);
    #1;
    reset_vals("rst_hold");
    @(negedge clk);
    reset_n = 1'b1;
    wait_edge(2);
    chk("fs_pre_rel", fs1, 0);
    at_pix(0, 0, 0);
    chk("fs_after_rel", fs1, 1);
    scan_frame(1, 1'b0, 1'b1);

    reset_n = 1'b0;
    h_end = 12'd18; v_end = 12'd10;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    at_pix(0, 15, 3);
    pix("oog_last_cell", 24'h32D8E0);
    at_pix(0, 16, 3);
    pix("oog_col16", 24'hFFFFFF);
    at_pix(0, 17, 3);
    pix("oog_edge_col", 24'h32D8E0);
    chk("oog_de17", de1, 1);
    at_pix(0, 5, 6);
    pix("oog_cell3_in", 24'h102030);
    at_pix(0, 5, 8);
    pix("oog_line8", 24'hFFFFFF);
    at_pix(0, 16, 8);
    pix("oog_corner", 24'hFFFFFF);
    at_pix(0, 5, 9);
    pix("oog_edge_line", 24'h32D8E0);
    at_pix(0, 18, 9);
    chk("oog_de18", de1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
